water_level_monitor: RTL

Probe-sampling and alarm stage clocked by the 100 kHz divided clock from the clock divider. It synchronizes and debounces N float/conductive probes, encodes them as a thermometer-coded water level and flags inconsistent probe patterns. A hysteretic alarm state machine drives high/low/fault flags and a pulsed buzzer with operator acknowledge.

---
 rtl/water_level_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/water_level_monitor.sv
// water_level_monitor
// Samples N float/conductive probes, debounces them, encodes a thermometer
// water level, flags inconsistent probe patterns and runs a hysteretic
// alarm state machine that drives level flags and a pulsed buzzer with
// operator acknowledge.

module water_level_monitor #(
    parameter  int N_PROBES    = 4,
    parameter  int DEBOUNCE    = 1000,
    parameter  int LOW_LVL     = 1,
    parameter  int HIGH_LVL    = 4,
    parameter  int HYST        = 1,
    parameter  int BEEP_CYCLES = 50000,
    localparam int LW          = $clog2(N_PROBES + 1)
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [N_PROBES-1:0] probe_in,
    input  logic                alarm_ack,
    output logic [LW-1:0]       level,
    output logic                level_valid,
    output logic                high_alarm,
    output logic                low_alarm,
    output logic                fault,
    output logic                buzzer
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [N_PROBES-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_NORMAL,
        S_LOW,
        S_HIGH,
        S_FAULT
    } state_t;

    logic [N_PROBES-1:0] sync1, sync2, deb;
    logic [CW-1:0]       cnt [N_PROBES];
    logic                cand_valid;
    logic [LW-1:0]       cand_lvl;
    logic                bad;
    state_t              state, state_nx;
    int                  lvl_i;
    logic                silence, silence_eff, beep_on;
    logic [BW-1:0]       beep_cnt;

    // Two-flop synchronizer for the asynchronous probe inputs.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= probe_in;
            sync2 <= sync1;
        end
    end

    // Per-probe debounce: accept a change only after DEBOUNCE differing cycles.
    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // cleared by the reset loop like any other register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < N_PROBES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PROBES; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Thermometer decode: find k with deb == (1<<k)-1, else pattern invalid.
    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
        cand_valid = 1'b0;
        cand_lvl   = '0;
        for (int k = 0; k <= N_PROBES; k++) begin
            if (deb == (ALL_ONES >> (N_PROBES - k))) begin
                cand_valid = 1'b1;
                cand_lvl   = LW'(k);
            end
        end
    end

    // Registered level, change pulse and bad-pattern flag.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            level       <= '0;
            level_valid <= 1'b0;
            bad         <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (!cand_valid) begin
                bad <= 1'b1;
            end else begin
                bad <= 1'b0;
                if (cand_lvl != level) begin
                    level       <= cand_lvl;
                    level_valid <= 1'b1;
                end
            end
        end
    end

    // Alarm state register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state <= S_NORMAL;
        else      state <= state_nx;
    end

    assign lvl_i = int'(level);

    // Next-state logic with priority bad > high > low and hysteretic exits.
    always_comb begin
        state_nx = state;
        case (state)
            S_NORMAL: begin
                if (bad)                        state_nx = S_FAULT;
                else if (lvl_i >= HIGH_LVL)     state_nx = S_HIGH;
                else if (lvl_i <= LOW_LVL)      state_nx = S_LOW;
            end
            S_HIGH: begin
                if (bad)                        state_nx = S_FAULT;
                else if (lvl_i <= LOW_LVL)      state_nx = S_LOW;
                else if (lvl_i < HIGH_LVL - HYST) state_nx = S_NORMAL;
            end
            S_LOW: begin
                if (bad)                        state_nx = S_FAULT;
                else if (lvl_i >= HIGH_LVL)     state_nx = S_HIGH;
                else if (lvl_i > LOW_LVL + HYST) state_nx = S_NORMAL;
            end
            S_FAULT: begin
                if (!bad)                       state_nx = S_NORMAL;
            end
            default:                            state_nx = S_NORMAL;
        endcase
    end

    assign high_alarm = (state == S_HIGH);
    assign low_alarm  = (state == S_LOW);
    assign fault      = (state == S_FAULT);

    // An acknowledge in an alarm state mutes the buzzer on the same edge.
    assign silence_eff = silence | (alarm_ack && (state != S_NORMAL));

    // Silence flag, beep timer and registered buzzer drive.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            silence  <= 1'b0;
            beep_on  <= 1'b0;
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end else begin
            case (state)
                S_FAULT:        buzzer <= !silence_eff;
                S_LOW, S_HIGH:  buzzer <= !silence_eff && beep_on;
                default:        buzzer <= 1'b0;
            endcase

            if (state_nx != state) begin
                silence  <= 1'b0;
                beep_on  <= 1'b1;
                beep_cnt <= '0;
            end else begin
                if (alarm_ack && (state != S_NORMAL)) silence <= 1'b1;
                if ((state == S_LOW) || (state == S_HIGH)) begin
                    if (beep_cnt == BW'(BEEP_CYCLES - 1)) begin
                        beep_cnt <= '0;
                        beep_on  <= !beep_on;
                    end else begin
                        beep_cnt <= beep_cnt + BW'(1);
                    end
                end
            end
        end
    end

endmodule
